dds_cmd_sequencer: RTL and testbench
====================================

// Module: dds_cmd_sequencer
// PURPOSE
//  Queues host DDS commands {board sel, cmd, data} and issues them one at a time to the shared AD9959 SPI driver bus.
//  Drives sel/cmd/data/cmdtrig and tracks the selected board's ready line.
//  On reset it autonomously runs a boot sequence (CMD_INIT then CMD_MPD) on each board in BOOT_MASK.
//  Sits between the host endpoint decode and the per-board AD9959 SPI drivers.
// PARAMETERS
//  DEPTH_LOG2  4      command FIFO depth = 2**DEPTH_LOG2 entries of 41 bits {sel[3:0],cmd[4:0],data[31:0]}
//  BOOT_MASK   16'h1  bit n set -> board n receives CMD_INIT then CMD_MPD after reset
//  TIMEOUT     16'd255 max cycles waiting for ready to return high before abort
//  GAP         4'd2   idle cycles between commands, sel held stable
// PORTS
//  clk_i         in   1   system clock (driver clock)
//  reset_n_i     in   1   asynchronous active-low reset
//  wr_en_i       in   1   push {wr_sel_i,wr_cmd_i,wr_data_i} into FIFO
//  wr_sel_i      in   4   target board index
//  wr_cmd_i      in   5   driver command code
//  wr_data_i     in   32  command argument
//  clear_err_i   in   1   clears sticky err_o / ovf_o
//  ready_i       in   1   ready from driver bus (unselected boards report 1)
//  sel_o         out  4   board select to drivers
//  cmd_o         out  5   command to drivers
//  data_o        out  32  data to drivers
//  cmdtrig_o     out  1   one-cycle command strobe
//  busy_o        out  1   high when not IDLE or FIFO non-empty
//  done_o        out  1   one-cycle pulse per completed command
//  err_o         out  1   sticky: timeout or missing busy response
//  ovf_o         out  1   sticky: write while FIFO full
//  level_o       out  DEPTH_LOG2+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): outputs 0 except sel_o=4'hF.
//   4'hF is never a board index -> idle parking value.
//   FIFO emptied, state=BOOT, boot board ptr=0, boot step=INIT.
//  States:
//   BOOT: scan ptr 0..15.
//    Unmasked board -> ptr+1 (one cycle each).
//    Masked board -> load {ptr,CMD_INIT/CMD_MPD,0} -> SETUP.
//    After ptr 15 -> IDLE.
//    Host writes are accepted into the FIFO during BOOT.
//   IDLE: FIFO non-empty -> pop; head registered onto sel_o/cmd_o/data_o -> SETUP.
//   SETUP: 1 cycle, bus stable; ready_i=1 -> TRIG, else remain.
//   TRIG: cmdtrig_o=1 exactly one cycle -> ACK.
//   ACK: expect ready_i=0 within 2 cycles -> WAIT.
//    Otherwise set err_o -> GAP.
//   WAIT: count cycles; ready_i=1 -> done_o pulse -> GAP.
//    Count reaches TIMEOUT -> err_o=1 -> GAP.
//   GAP: GAP cycles with sel_o/cmd_o held -> return to BOOT if boot pending, else IDLE.
//    Holding cmd_o through GAP keeps the driver's READ data-path mux stable.
//  sel_o/cmd_o/data_o change only in IDLE->SETUP or BOOT->SETUP transitions; never mid-transfer.
//  Back-to-back throughput: 1 (load) + 1 (SETUP) + 1 (TRIG) + ACK + serial time + GAP.
//  FIFO:
//   Push and pop in the same cycle when full -> both proceed, level unchanged.
//   Push when full with no pop -> dropped, ovf_o=1.
//   Push when empty with IDLE -> the entry is not visible until the next cycle (registered FIFO).
//  clear_err_i and a new error in the same cycle -> error wins (flag stays 1).
//  Boot steps per masked board: INIT then MPD, then advance ptr.
//  Reset mid-transfer: cmdtrig_o drops immediately (async); the driver is recovered by its own reset.
// STRUCTURE
//  Shared package dds_pkg: CMD_INIT=5'h0, CMD_CH=5'h1, CMD_FRQ=5'h2, CMD_PHS=5'h3, CMD_AMP=5'h4,
//   CMD_MPD=5'h5, CMD_MTYP=5'h6, CMD_MSTR=5'h7, CMD_MSTP=5'h8, CMD_READ=5'h1F;
//   state encoding, SEL_PARK=4'hF.
//  Sub-module dds_cmd_fifo: synchronous FIFO, width 41, depth 2**DEPTH_LOG2, outputs full/empty/level.
//  Top: FSM, boot pointer, timeout counter, gap counter, sticky flags.
// TESTING
//  1. BOOT_MASK=16'h0005, ready model with 4-cycle busy:
//     -> sel/cmd sequence 0/INIT, 0/MPD, 2/INIT, 2/MPD; 4 done_o pulses; then IDLE.
//  2. Push {1,CMD_FRQ,32'h1234_5678}:
//     -> sel_o=1, cmd_o=2, data_o held; one cmdtrig_o; done_o after ready returns; level_o 1->0.
//  3. Fill 16 entries plus a 17th push:
//     -> ovf_o=1, level_o=16; all 16 issued in order; clear_err_i clears ovf_o.
//  4. Ready model never deasserts after TRIG:
//     -> err_o=1 two cycles after ACK entry; next command still issued.
//  5. Ready model holds ready low forever:
//     -> err_o after 255 WAIT cycles; sequencer reaches IDLE.
//  6. reset_n_i low during WAIT:
//     -> outputs reset same cycle; sel_o=4'hF; boot sequence restarts on release.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS command path: AD9959 driver command codes,
// sequencer state encoding and the 41-bit queued command record.
package dds_pkg;

  localparam logic [4:0] CMD_INIT = 5'h00;
  localparam logic [4:0] CMD_CH   = 5'h01;
  localparam logic [4:0] CMD_FRQ  = 5'h02;
  localparam logic [4:0] CMD_PHS  = 5'h03;
  localparam logic [4:0] CMD_AMP  = 5'h04;
  localparam logic [4:0] CMD_MPD  = 5'h05;
  localparam logic [4:0] CMD_MTYP = 5'h06;
  localparam logic [4:0] CMD_MSTR = 5'h07;
  localparam logic [4:0] CMD_MSTP = 5'h08;
  localparam logic [4:0] CMD_READ = 5'h1F;

  // 4'hF is never a board index, so it doubles as the idle parking select.
  localparam logic [3:0] SEL_PARK = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_TRIG  = 3'd3,
    ST_ACK   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_GAP   = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic [3:0]  sel;
    logic [4:0]  cmd;
    logic [31:0] data;
  } dds_cmd_t;

  function automatic dds_cmd_t boot_cmd(input logic [3:0] board, input logic mpd_step);
    dds_cmd_t c;
    c.sel  = board;
    c.cmd  = mpd_step ? CMD_MPD : CMD_INIT;
    c.data = 32'h0000_0000;
    return c;
  endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// Registered command FIFO; head entry is presented show-ahead from storage,
// and a push while full is only accepted when a pop frees a slot in the same cycle.
module dds_cmd_fifo
  import dds_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  push_i,
  input  dds_cmd_t              din_i,
  input  logic                  pop_i,
  output dds_cmd_t              dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  nonempty_nx_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  dds_cmd_t              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == {(DEPTH_LOG2+1){1'b0}});
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign dout_o    = mem_q[rd_ptr_q];
  assign level_o   = count_q;
  assign nonempty_nx_o = (count_d != {(DEPTH_LOG2+1){1'b0}});

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      count_q  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dds_cmd_sequencer.sv
// Issues queued host DDS commands one at a time onto the shared AD9959 driver bus,
// preceded after reset by an INIT/MPD boot sequence on every board in BOOT_MASK.
module dds_cmd_sequencer
  import dds_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] BOOT_MASK  = 16'h0001,
  parameter logic [15:0] TIMEOUT    = 16'd255,
  parameter logic [3:0]  GAP        = 4'd2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  wr_en_i,
  input  logic [3:0]            wr_sel_i,
  input  logic [4:0]            wr_cmd_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  clear_err_i,
  input  logic                  ready_i,
  output logic [3:0]            sel_o,
  output logic [4:0]            cmd_o,
  output logic [31:0]           data_o,
  output logic                  cmdtrig_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  ovf_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  seq_state_e  state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [31:0] data_q, data_d;
  logic        cmdtrig_q, cmdtrig_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  boot_ptr_q, boot_ptr_d;
  logic        boot_mpd_q, boot_mpd_d;
  logic        boot_done_q, boot_done_d;
  logic        ack_cnt_q, ack_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;

  dds_cmd_t    wr_entry_s, head_s, boot_entry_s;
  logic        fifo_full_s, fifo_empty_s, fifo_nonempty_nx_s;
  logic        pop_s, err_set_s, ovf_set_s;

  assign wr_entry_s   = {wr_sel_i, wr_cmd_i, wr_data_i};
  assign boot_entry_s = boot_cmd(boot_ptr_q, boot_mpd_q);

  dds_cmd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .push_i        (wr_en_i),
    .din_i         (wr_entry_s),
    .pop_i         (pop_s),
    .dout_o        (head_s),
    .full_o        (fifo_full_s),
    .empty_o       (fifo_empty_s),
    .nonempty_nx_o (fifo_nonempty_nx_s),
    .level_o       (level_o)
  );

  // Sequencer FSM: next state, bus loads, counters and event strobes.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmdtrig_d   = 1'b0;
    done_d      = 1'b0;
    boot_ptr_d  = boot_ptr_q;
    boot_mpd_d  = boot_mpd_q;
    boot_done_d = boot_done_q;
    ack_cnt_d   = ack_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pop_s       = 1'b0;
    err_set_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_done_q) begin
          state_d = ST_IDLE;
        end else if (BOOT_MASK[boot_ptr_q]) begin
          {sel_d, cmd_d, data_d} = boot_entry_s;
          state_d = ST_SETUP;
          if (boot_mpd_q) begin
            boot_mpd_d = 1'b0;
            if (boot_ptr_q == 4'hF) begin
              boot_done_d = 1'b1;
            end else begin
              boot_ptr_d = boot_ptr_q + 4'd1;
            end
          end else begin
            boot_mpd_d = 1'b1;
          end
        end else if (boot_ptr_q == 4'hF) begin
          boot_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          boot_ptr_d = boot_ptr_q + 4'd1;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          {sel_d, cmd_d, data_d} = head_s;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (ready_i) begin
          cmdtrig_d = 1'b1;
          state_d   = ST_TRIG;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_TRIG: begin
        ack_cnt_d = 1'b0;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        if (!ready_i) begin
          wait_cnt_d = 16'd0;
          state_d    = ST_WAIT;
        end else if (ack_cnt_q) begin
          err_set_s = 1'b1;
          gap_cnt_d = 4'd0;
          state_d   = ST_GAP;
        end else begin
          ack_cnt_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ready_i) begin
          done_d    = 1'b1;
          gap_cnt_d = 4'd0;
          state_d   = ST_GAP;
        end else if (wait_cnt_q == TIMEOUT - 16'd1) begin
          err_set_s = 1'b1;
          gap_cnt_d = 4'd0;
          state_d   = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        // sel/cmd stay on the bus here so the driver's READ mux does not glitch.
        if (gap_cnt_q == GAP - 4'd1) begin
          state_d = boot_done_q ? ST_IDLE : ST_BOOT;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags (a new error beats a simultaneous clear) and the busy indication.
  always_comb begin
    ovf_set_s = wr_en_i && fifo_full_s && !pop_s;
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (clear_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clear_err_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    busy_d = (state_d != ST_IDLE) || fifo_nonempty_nx_s;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_BOOT;
      sel_q       <= SEL_PARK;
      cmd_q       <= 5'h00;
      data_q      <= 32'h0000_0000;
      cmdtrig_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      boot_ptr_q  <= 4'd0;
      boot_mpd_q  <= 1'b0;
      boot_done_q <= 1'b0;
      ack_cnt_q   <= 1'b0;
      wait_cnt_q  <= 16'd0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmdtrig_q   <= cmdtrig_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      boot_ptr_q  <= boot_ptr_d;
      boot_mpd_q  <= boot_mpd_d;
      boot_done_q <= boot_done_d;
      ack_cnt_q   <= ack_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign sel_o     = sel_q;
  assign cmd_o     = cmd_q;
  assign data_o    = data_q;
  assign cmdtrig_o = cmdtrig_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// Self-checking bench: driver ready model, command scoreboard, vector table and random traffic.
module tb_dds_cmd_sequencer;
  import dds_pkg::*;

  typedef logic [40:0] ent_t;
  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  cmd;
    logic [31:0] data;
    int          mode;      // 0: ready returns after blen cycles, 1: ready stuck low
    int          blen;      // 0: ready never drops
    int          err_lat;   // cycles from strobe to err_o rising, 0 = no error
    int          done_lat;  // cycles from strobe to done_o, 0 = no done
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_sel_i = 4'd0;
  logic [4:0]  wr_cmd_i = 5'd0;
  logic [31:0] wr_data_i = 32'd0;
  logic        clear_err_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [3:0]  sel_o;
  logic [4:0]  cmd_o;
  logic [31:0] data_o;
  logic        cmdtrig_o, busy_o, done_o, err_o, ovf_o;
  logic [4:0]  level_o;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int busy_len = 4;
  int rdy_cnt = 0;
  int cyc = 0, done_cnt = 0, trig_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic err_prev = 1'b0;
  ent_t last_trig = '0;
  ent_t obs_q[$];
  ent_t exp_q[$];

  always #5 clk_i = ~clk_i;

  dds_cmd_sequencer #(.DEPTH_LOG2(4), .BOOT_MASK(16'h0005), .TIMEOUT(16'd255), .GAP(4'd2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_cmd_i(wr_cmd_i), .wr_data_i(wr_data_i), .clear_err_i(clear_err_i), .ready_i(ready_i),
    .sel_o(sel_o), .cmd_o(cmd_o), .data_o(data_o), .cmdtrig_o(cmdtrig_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o), .level_o(level_o));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Driver ready model: ready drops on the strobe and returns after busy_len cycles.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!reset_n_i) rdy_cnt = 0;
      else if (cmdtrig_o) rdy_cnt = busy_len;
      else if (rdy_cnt > 0 && rdy_mode == 0) rdy_cnt--;
      ready_i = (rdy_cnt == 0);
    end
  end

  // Bus monitor: logs every strobe and checks the bus is still held at done.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (cmdtrig_o) begin
        obs_q.push_back({sel_o, cmd_o, data_o});
        last_trig = {sel_o, cmd_o, data_o};
        trig_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("bus_held_at_done", {23'd0, sel_o, cmd_o, data_o}, {23'd0, last_trig});
      end
      if (err_o && !err_prev) err_cyc = cyc;
      err_prev = err_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [3:0] s, input logic [4:0] c, input logic [31:0] d);
    wr_en_i = 1'b1; wr_sel_i = s; wr_cmd_i = c; wr_data_i = d;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || level_o != 5'd0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle: busy_o=%0b level_o=%0d after %0d cycles, required idle", name, busy_o, level_o, n);
    end
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_entry%0d", name, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic load_boot_exp();
    exp_q.delete();
    exp_q.push_back({4'd0, CMD_INIT, 32'd0});
    exp_q.push_back({4'd0, CMD_MPD, 32'd0});
    exp_q.push_back({4'd2, CMD_INIT, 32'd0});
    exp_q.push_back({4'd2, CMD_MPD, 32'd0});
  endtask

  initial begin
    vec_t tbl[6];
    logic [4:0] cmds[10];
    ent_t first_ent, v_ent;
    int d0, found;

    tbl[0] = '{sel: 4'd3,  cmd: CMD_PHS,  data: 32'h0000_1111, mode: 0, blen: 4, err_lat: 0,   done_lat: 5};
    tbl[1] = '{sel: 4'd14, cmd: CMD_AMP,  data: 32'hFFFF_FFFF, mode: 0, blen: 2, err_lat: 0,   done_lat: 3};
    tbl[2] = '{sel: 4'd2,  cmd: CMD_READ, data: 32'h0000_00A5, mode: 0, blen: 0, err_lat: 3,   done_lat: 0};
    tbl[3] = '{sel: 4'd5,  cmd: CMD_CH,   data: 32'h0000_0003, mode: 0, blen: 3, err_lat: 0,   done_lat: 4};
    tbl[4] = '{sel: 4'd4,  cmd: CMD_MSTR, data: 32'h0000_0000, mode: 1, blen: 4, err_lat: 257, done_lat: 0};
    tbl[5] = '{sel: 4'd7,  cmd: CMD_MSTP, data: 32'h8000_0001, mode: 0, blen: 6, err_lat: 0,   done_lat: 7};
    cmds = '{CMD_INIT, CMD_CH, CMD_FRQ, CMD_PHS, CMD_AMP, CMD_MPD, CMD_MTYP, CMD_MSTR, CMD_MSTP, CMD_READ};

    // Reset values while reset is held.
    repeat (3) @(negedge clk_i);
    check("rst_sel", 64'(sel_o), 64'hF);
    check("rst_cmd", 64'(cmd_o), 64'h0);
    check("rst_data", 64'(data_o), 64'h0);
    check("rst_cmdtrig", 64'(cmdtrig_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_done", 64'(done_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_ovf", 64'(ovf_o), 64'h0);
    check("rst_level", 64'(level_o), 64'h0);

    // Boot sequence for boards 0 and 2.
    load_boot_exp();
    reset_n_i = 1'b1;
    wait_idle("boot", 2000);
    compare_queues("boot");
    check("boot_done_pulses", 64'(done_cnt), 64'd4);
    check("boot_err", 64'(err_o), 64'h0);

    // Single FRQ command with level and bus checks.
    obs_q.delete();
    d0 = done_cnt;
    push(4'd1, CMD_FRQ, 32'h1234_5678);
    check("frq_level_after_push", 64'(level_o), 64'd1);
    @(negedge clk_i);
    check("frq_level_after_pop", 64'(level_o), 64'd0);
    check("frq_bus", {23'd0, sel_o, cmd_o, data_o}, {23'd0, 4'd1, CMD_FRQ, 32'h1234_5678});
    wait_idle("frq", 500);
    check("frq_strobes", 64'(obs_q.size()), 64'd1);
    check("frq_done", 64'(done_cnt - d0), 64'd1);

    // Vector table: handshake outcomes and latencies.
    for (int i = 0; i < 6; i++) begin
      obs_q.delete();
      d0 = done_cnt;
      err_cyc = 0;
      rdy_mode = tbl[i].mode;
      busy_len = tbl[i].blen;
      push(tbl[i].sel, tbl[i].cmd, tbl[i].data);
      wait_idle($sformatf("vec%0d", i), 800);
      check($sformatf("vec%0d_strobes", i), 64'(obs_q.size()), 64'd1);
      if (obs_q.size() > 0)
        check($sformatf("vec%0d_bus", i), {23'd0, obs_q[0]}, {23'd0, tbl[i].sel, tbl[i].cmd, tbl[i].data});
      if (tbl[i].err_lat > 0) begin
        check($sformatf("vec%0d_err", i), 64'(err_o), 64'h1);
        check($sformatf("vec%0d_err_latency", i), 64'(err_cyc - trig_cyc), 64'(tbl[i].err_lat));
      end else begin
        check($sformatf("vec%0d_no_err", i), 64'(err_o), 64'h0);
      end
      check($sformatf("vec%0d_done_count", i), 64'(done_cnt - d0), (tbl[i].done_lat > 0) ? 64'd1 : 64'd0);
      if (tbl[i].done_lat > 0)
        check($sformatf("vec%0d_done_latency", i), 64'(done_cyc - trig_cyc), 64'(tbl[i].done_lat));
      pulse_clear();
      check($sformatf("vec%0d_err_cleared", i), 64'(err_o), 64'h0);
    end
    rdy_mode = 0;
    busy_len = 4;

    // FIFO fill during boot, overflow, then push coinciding with a pop while full.
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    obs_q.delete();
    load_boot_exp();
    reset_n_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(4'(i % 15), CMD_AMP, 32'hA000_0000 + 32'(i));
      exp_q.push_back({4'(i % 15), CMD_AMP, 32'hA000_0000 + 32'(i)});
    end
    v_ent = {4'd9, CMD_MSTP, 32'hDEAD_BEEF};
    push(4'd9, CMD_MSTP, 32'hDEAD_BEEF);
    check("ovf_level_full", 64'(level_o), 64'd16);
    check("ovf_flag", 64'(ovf_o), 64'h1);
    first_ent = {4'd0, CMD_AMP, 32'hA000_0000};
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      push(4'd9, CMD_MSTP, 32'hDEAD_BEEF);
      if ({sel_o, cmd_o, data_o} == first_ent) found = 1;
    end
    check("full_push_pop_seen", 64'(found), 64'd1);
    check("full_push_pop_level", 64'(level_o), 64'd16);
    exp_q.push_back(v_ent);
    wait_idle("ovf", 3000);
    compare_queues("ovf");
    check("ovf_sticky", 64'(ovf_o), 64'h1);
    pulse_clear();
    check("ovf_cleared", 64'(ovf_o), 64'h0);

    // Random traffic against the in-order scoreboard.
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    for (int k = 0; k < 40; k++) begin
      logic [3:0]  s;
      logic [4:0]  c;
      logic [31:0] d;
      int guard = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      while (level_o >= 5'd14 && guard < 200) begin
        @(negedge clk_i);
        guard++;
      end
      s = 4'($urandom_range(0, 14));
      c = cmds[$urandom_range(0, 9)];
      d = $urandom;
      busy_len = $urandom_range(2, 6);
      push(s, c, d);
      exp_q.push_back({s, c, d});
    end
    wait_idle("rand", 5000);
    compare_queues("rand");
    check("rand_done_count", 64'(done_cnt - d0), 64'd40);
    check("rand_err", 64'(err_o), 64'h0);
    check("rand_ovf", 64'(ovf_o), 64'h0);

    // Reset while waiting on a stuck ready line; boot must restart.
    rdy_mode = 1;
    busy_len = 4;
    obs_q.delete();
    push(4'd6, CMD_FRQ, 32'h0BAD_F00D);
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(posedge clk_i);
      #2;
      if (cmdtrig_o) found = 1;
    end
    check("mid_reset_strobe_seen", 64'(found), 64'd1);
    repeat (5) @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("mid_reset_sel", 64'(sel_o), 64'hF);
    check("mid_reset_cmd_data", {27'd0, cmd_o, data_o}, 64'h0);
    check("mid_reset_flags", {59'd0, cmdtrig_o, busy_o, done_o, err_o, ovf_o}, 64'h0);
    rdy_mode = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    obs_q.delete();
    load_boot_exp();
    d0 = done_cnt;
    reset_n_i = 1'b1;
    wait_idle("reboot", 2000);
    compare_queues("reboot");
    check("reboot_done_pulses", 64'(done_cnt - d0), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
